// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller between the bridge HWInt lines and CP0.
// Offers per-line level/edge sensing, masking, global enable, pending/overflow status and a priority ID.
module irq_controller #(
  parameter int NIRQ = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NIRQ-1:0] IrqIn,
  input  logic [31:0]     Addr,
  input  logic            WE,
  input  logic [31:0]     WD,
  output logic [31:0]     RD,
  output logic [NIRQ-1:0] HWIntOut,
  output logic            IntReq
);

  logic            gie;
  logic [NIRQ-1:0] mask, mode, pending, ovf, prev;
  logic [NIRQ-1:0] mode_n, rise, clr_p, clr_o, to_edge, pend_n, ovf_n;
  logic [2:0]      sel, id;

  assign sel     = Addr[4:2];
  assign mode_n  = (WE && sel == 3'd2) ? WD[NIRQ-1:0] : mode;
  assign clr_p   = (WE && sel == 3'd3) ? WD[NIRQ-1:0] : '0;
  assign clr_o   = (WE && sel == 3'd4) ? WD[NIRQ-1:0] : '0;
  assign rise    = IrqIn & ~prev;
  assign to_edge = mode_n & ~mode;

  // Lines are judged against the mode they hold after this edge, so a rise
  // coinciding with a level-to-edge switch still latches.
  assign pend_n = (mode_n & ~to_edge & (rise | (pending & ~clr_p)))
                | (to_edge & rise)
                | (~mode_n & IrqIn);
  assign ovf_n  = (mode_n & ~to_edge & rise & pending)
                | (~to_edge & ovf & ~clr_o);

  always_ff @(posedge clk) begin
    if (reset) begin
      gie     <= 1'b1;
      mask    <= '1;
      mode    <= '0;
      pending <= '0;
      ovf     <= '0;
      prev    <= '0;
    end else begin
      if (WE && sel == 3'd0) gie  <= WD[0];
      if (WE && sel == 3'd1) mask <= WD[NIRQ-1:0];
      mode    <= mode_n;
      pending <= pend_n;
      ovf     <= ovf_n;
      prev    <= IrqIn;
    end
  end

  assign HWIntOut = pending & mask & {NIRQ{gie}};
  assign IntReq   = |HWIntOut;

  // Later iterations overwrite earlier ones, leaving the highest active index.
  always_comb begin
    id = '0;
    for (int i = 0; i < NIRQ; i++)
      if (HWIntOut[i]) id = 3'(i);
  end

  always_comb begin
    RD = '0;
    case (sel)
      3'd0: RD = {31'b0, gie};
      3'd1: RD = {{(32-NIRQ){1'b0}}, mask};
      3'd2: RD = {{(32-NIRQ){1'b0}}, mode};
      3'd3: RD = {{(32-NIRQ){1'b0}}, pending};
      3'd4: RD = {{(32-NIRQ){1'b0}}, ovf};
      3'd5: RD = {IntReq, 28'b0, id};
      default: RD = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed and randomized checks of irq_controller against a per-line behavioural model.
module tb_irq_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  IrqIn;
  logic [31:0] Addr;
  logic        WE;
  logic [31:0] WD;
  logic [31:0] RD;
  logic [5:0]  HWIntOut;
  logic        IntReq;

  int tests = 0;
  int fails = 0;

  logic       m_gie;
  logic [5:0] m_mask, m_mode, m_pend, m_ovf, m_prev;

  irq_controller #(.NIRQ(6)) dut (
    .clk(clk), .reset(reset), .IrqIn(IrqIn), .Addr(Addr), .WE(WE), .WD(WD),
    .RD(RD), .HWIntOut(HWIntOut), .IntReq(IntReq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] m_out();
    return m_gie ? (m_pend & m_mask) : 6'h00;
  endfunction

  function automatic logic [31:0] m_rd(input logic [2:0] idx);
    logic [5:0]  o;
    logic [31:0] r;
    o = m_out();
    r = 32'h0;
    case (idx)
      3'd0: r = {31'b0, m_gie};
      3'd1: r = {26'b0, m_mask};
      3'd2: r = {26'b0, m_mode};
      3'd3: r = {26'b0, m_pend};
      3'd4: r = {26'b0, m_ovf};
      3'd5: begin
        for (int i = 0; i < 6; i++) if (o[i]) r[2:0] = 3'(i);
        r[31] = (o != 6'h00);
      end
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // Model advances one clock using the inputs currently presented.
  task automatic model_step();
    logic [2:0] idx;
    logic [5:0] nm, np, no;
    idx = Addr[4:2];
    if (reset) begin
      m_gie = 1'b1; m_mask = 6'h3F; m_mode = 6'h00;
      m_pend = 6'h00; m_ovf = 6'h00; m_prev = 6'h00;
      return;
    end
    nm = (WE && idx == 3'd2) ? WD[5:0] : m_mode;
    np = m_pend;
    no = m_ovf;
    for (int i = 0; i < 6; i++) begin
      bit r;
      r = IrqIn[i] && !m_prev[i];
      if (!nm[i]) begin
        np[i] = IrqIn[i];
        if (WE && idx == 3'd4 && WD[i]) no[i] = 1'b0;
      end else if (!m_mode[i]) begin
        np[i] = r;
        no[i] = 1'b0;
      end else begin
        if (WE && idx == 3'd3 && WD[i]) np[i] = 1'b0;
        if (WE && idx == 3'd4 && WD[i]) no[i] = 1'b0;
        if (r) begin
          if (m_pend[i]) no[i] = 1'b1;
          np[i] = 1'b1;
        end
      end
    end
    if (WE && idx == 3'd0) m_gie = WD[0];
    if (WE && idx == 3'd1) m_mask = WD[5:0];
    m_mode = nm; m_pend = np; m_ovf = no; m_prev = IrqIn;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("hwint_model", {26'b0, HWIntOut}, {26'b0, m_out()});
    check("intreq_model", {31'b0, IntReq}, {31'b0, (m_out() != 6'h00)});
  endtask

  task automatic applyStimulus(input logic [2:0] idx, input logic [31:0] data);
    Addr = {27'b0, idx, 2'b00};
    WD   = data;
    WE   = 1'b1;
    tick();
    WE   = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [2:0] idx, input logic [31:0] exp);
    Addr = {27'b0, idx, 2'b00};
    WE   = 1'b0;
    #1;
    check(tag, RD, exp);
    check({tag, "_model"}, RD, m_rd(idx));
  endtask

  initial begin
    reset = 1'b1; IrqIn = 6'h00; Addr = 32'h0; WE = 1'b0; WD = 32'h0;
    m_gie = 1'b0; m_mask = 6'h00; m_mode = 6'h00; m_pend = 6'h00; m_ovf = 6'h00; m_prev = 6'h00;
    tick(); tick();
    reset = 1'b0;
    check("reset_hwint", {26'b0, HWIntOut}, 32'h0);
    checkOutput("reset_ctrl", 3'd0, 32'h1);
    checkOutput("reset_mask", 3'd1, 32'h3F);
    checkOutput("reset_mode", 3'd2, 32'h0);
    checkOutput("reset_pend", 3'd3, 32'h0);

    // Default level passthrough.
    IrqIn = 6'h01; tick();
    check("pass_hwint", {26'b0, HWIntOut}, 32'h01);
    checkOutput("pass_id", 3'd5, 32'h8000_0000);
    IrqIn = 6'h00; tick();
    check("pass_drop", {26'b0, HWIntOut}, 32'h0);

    // Edge latch and W1C on line 2.
    applyStimulus(3'd2, 32'h04);
    IrqIn = 6'h04; tick();
    IrqIn = 6'h00; tick();
    checkOutput("edge_pend", 3'd3, 32'h04);
    check("edge_intreq", {31'b0, IntReq}, 32'h1);
    applyStimulus(3'd3, 32'h04);
    checkOutput("edge_clr", 3'd3, 32'h0);
    IrqIn = 6'h04; applyStimulus(3'd3, 32'h04);
    IrqIn = 6'h00;
    checkOutput("edge_setwins", 3'd3, 32'h04);

    // Overflow and held-high line.
    applyStimulus(3'd3, 32'h04);
    IrqIn = 6'h04; tick(); IrqIn = 6'h00; tick();
    IrqIn = 6'h04; tick(); IrqIn = 6'h00; tick();
    checkOutput("ovf_set", 3'd4, 32'h04);
    applyStimulus(3'd4, 32'h04);
    checkOutput("ovf_clr", 3'd4, 32'h0);
    applyStimulus(3'd3, 32'h04);
    IrqIn = 6'h04; tick(); tick(); tick();
    checkOutput("held_once", 3'd3, 32'h04);
    applyStimulus(3'd3, 32'h04);
    tick();
    checkOutput("held_norepeat", 3'd3, 32'h0);
    checkOutput("held_noovf", 3'd4, 32'h0);
    IrqIn = 6'h00;

    // Mask and global enable.
    applyStimulus(3'd2, 32'h00);
    IrqIn = 6'h12; tick();
    applyStimulus(3'd1, 32'h02);
    check("mask_hwint", {26'b0, HWIntOut}, 32'h02);
    checkOutput("mask_id", 3'd5, 32'h8000_0001);
    applyStimulus(3'd0, 32'h00);
    check("gie_hwint", {26'b0, HWIntOut}, 32'h0);
    checkOutput("gie_pend", 3'd3, 32'h12);

    // Priority.
    applyStimulus(3'd0, 32'h01);
    applyStimulus(3'd1, 32'h3F);
    IrqIn = 6'b101001; tick();
    checkOutput("prio_5", 3'd5, 32'h8000_0005);
    IrqIn = 6'b001001; tick();
    checkOutput("prio_3", 3'd5, 32'h8000_0003);

    // Edge-to-level switch with the line low.
    IrqIn = 6'h00;
    applyStimulus(3'd2, 32'h01);
    IrqIn = 6'h01; tick(); IrqIn = 6'h00; tick();
    checkOutput("sw_pend", 3'd3, 32'h01);
    applyStimulus(3'd2, 32'h00);
    checkOutput("sw_level", 3'd3, 32'h0);

    // Reset while an edge line is pending.
    applyStimulus(3'd2, 32'h08);
    applyStimulus(3'd1, 32'h15);
    IrqIn = 6'h08; tick(); IrqIn = 6'h00; tick();
    checkOutput("pre_rst_pend", 3'd3, 32'h08);
    reset = 1'b1; tick();
    check("rst_hwint", {26'b0, HWIntOut}, 32'h0);
    check("rst_intreq", {31'b0, IntReq}, 32'h0);
    checkOutput("rst_mask", 3'd1, 32'h3F);
    checkOutput("rst_mode", 3'd2, 32'h0);
    checkOutput("rst_pend", 3'd3, 32'h0);
    checkOutput("rst_ovf", 3'd4, 32'h0);
    checkOutput("rst_id", 3'd5, 32'h0);
    reset = 1'b0;

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic [2:0] ridx;
      ridx  = 3'($urandom_range(0, 7));
      IrqIn = 6'($urandom);
      reset = ($urandom_range(0, 99) == 0);
      Addr  = {27'($urandom), ridx, 2'($urandom)};
      WD    = $urandom;
      WE    = ($urandom_range(0, 3) == 0);
      #1;
      check("rand_rd", RD, m_rd(ridx));
      tick();
    end
    reset = 1'b0; WE = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
